gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl: RTL and testbench
==========================================================

// Module: gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl
// PURPOSE
//  Select sequencer and sampler that sits around a mux4 cell: drives S1/S0 through
//  the enabled channels, waits a settle window per channel, captures the mux output Z.
//  Packs one sweep of results into a 4-bit word with a valid/ack/overrun handshake
//  for the register or scan logic downstream.
// PARAMETERS
//  SETTLE    2  cycles each selected channel is held before Z is sampled (>=1)
//  SETTLE_W  2  width of settle counter; must satisfy 2**SETTLE_W >= SETTLE
// PORTS
//  CLK    in   1  clock, rising edge
//  RN     in   1  asynchronous active-low reset
//  START  in   1  begin a sweep; sampled only while BUSY=0
//  CONT   in   1  continuous mode: restart a new sweep as soon as one finishes
//  MASK   in   4  channel enable, bit k = I<k>; latched at sweep start
//  ZIN    in   1  mux4 output Z
//  S0     out  1  mux select LSB
//  S1     out  1  mux select MSB
//  BUSY   out  1  sweep in progress
//  DONE   out  1  one-cycle pulse: Q/VALID just updated
//  Q      out  4  result, bit k = sampled Z for channel k; 0 for masked channels
//  VALID  out  1  Q holds unread result
//  ACK    in   1  consumer has read Q; clears VALID and OVR
//  OVR    out  1  sticky: a sweep completed while VALID=1 with no ACK
// BEHAVIOUR
//  - Reset (RN=0, asynchronous, any state incl. mid-sweep): S1/S0=00, BUSY=0, DONE=0,
//    Q=0, VALID=0, OVR=0, FSM=IDLE, counters 0. Partial sweep results are discarded.
//  - FSM: IDLE -> SEL -> (SEL per next enabled ch) -> FIN -> IDLE, or FIN -> SEL if CONT.
//  - IDLE: S1/S0=00. START=1 and MASK!=0 at edge E0: latch MASK, BUSY=1, go to SEL with
//    lowest enabled channel. START with MASK==0 ignored (remain IDLE, no DONE).
//  - SEL: {S1,S0}=current channel k, held exactly SETTLE cycles; ZIN captured into
//    shadow bit k at the last edge of the window; then move to the next higher enabled
//    channel (masked channels cost zero cycles) or to FIN after the highest one.
//  - Timing, all 4 enabled: ch k selected between edges E0+k*SETTLE and E0+(k+1)*SETTLE;
//    sweep ends at edge E0+4*SETTLE. n enabled channels: sweep = n*SETTLE cycles.
//  - FIN (one cycle, edge after last sample): Q <= shadow (masked bits 0), DONE=1 for
//    that cycle, VALID=1. BUSY stays 1 through FIN; drops after unless CONT=1.
//  - CONT=1 at FIN: re-latch MASK and start next sweep (SEL) next cycle; BUSY stays 1.
//    If re-latched MASK==0, go to IDLE instead.
//  - START while BUSY=1 is ignored; MASK changes mid-sweep have no effect.
//  - Handshake: ACK=1 clears VALID and OVR. DONE with VALID=1 and ACK=0 -> OVR=1, Q
//    overwritten with new result. DONE and ACK same cycle -> VALID=1, OVR unchanged
//    (new data wins, no overrun). ACK with VALID=0 is harmless.
//  - Shadow register cleared at each sweep start; Q only changes on DONE.
//  - Outputs S1/S0/BUSY/DONE/Q/VALID/OVR are registered (no comb path from inputs).
// STRUCTURE
//  - Shared package: FSM state enum (IDLE, SEL, FIN), NCH=4 constant, channel index type.
//  - One sub-module: gf180mcu_fd_sc_mcu7t5v0__mux4_scan_nextch -- combinational
//    find-next-enabled-channel (mask, current ch -> next ch, last flag).
//  - Top holds FSM, settle counter, shadow/Q/VALID/OVR registers.
// TESTING (bench instantiates the mux4 cell driven by S1/S0, I0..I3 from stimulus)
//  - Reset: RN low mid-sweep (ch2 selected) -> all outputs 0 immediately, no DONE after.
//  - Full sweep SETTLE=2, I3..I0=1010, MASK=1111, START at E0 -> S=00,01,10,11 two
//    cycles each, DONE at cycle after E0+8, Q=1010, VALID=1, BUSY low next cycle.
//  - Masked: MASK=0101, I=1111 -> only ch0/ch2 selected, sweep 4 cycles, Q=0101.
//  - MASK=0000 with START -> BUSY stays 0, no DONE; START during BUSY ignored.
//  - CONT=1, no ACK, I toggled between sweeps -> back-to-back sweeps, BUSY never drops,
//    second DONE sets OVR=1 and Q=new value; ACK then clears VALID and OVR.
//  - ACK coincident with DONE -> VALID=1, OVR=0.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl_pkg.sv - shared types for the mux4 scan sequencer
package gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl_pkg;

  // Number of mux4 data inputs swept per pass
  localparam int NCH = 4;

  // Channel index, doubles as the {S1,S0} select value
  typedef logic [1:0] ch_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_scan_nextch.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_scan_nextch.sv - find next enabled channel in a mask
module gf180mcu_fd_sc_mcu7t5v0__mux4_scan_nextch
  import gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl_pkg::*;
(
  input  logic [NCH-1:0] mask_i,
  input  ch_t            ch_i,
  input  logic           incl_i,  // 1: ch_i itself is a candidate (used to find the first channel)
  output ch_t            next_o,
  output logic           last_o   // no enabled channel at or above the search start
);

  // Scan downward so the lowest qualifying channel is the one left standing
  always_comb begin
    next_o = '0;
    last_o = 1'b1;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask_i[k] && ((k > int'(ch_i)) || (incl_i && (k == int'(ch_i))))) begin
        next_o = ch_t'(k);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl.sv - mux4 select sequencer and result sampler
module gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl
  import gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl_pkg::*;
#(
  parameter int SETTLE   = 2,
  parameter int SETTLE_W = 2
) (
  input  logic           clk_i,
  input  logic           rn_i,
  input  logic           start_i,
  input  logic           cont_i,
  input  logic [NCH-1:0] mask_i,
  input  logic           zin_i,
  output logic           s0_o,
  output logic           s1_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [NCH-1:0] q_o,
  output logic           valid_o,
  input  logic           ack_i,
  output logic           ovr_o
);

  localparam logic [SETTLE_W-1:0] CNT_LAST = SETTLE_W'(SETTLE - 1);

  state_t                state_q,    state_d;
  ch_t                   ch_q,       ch_d;
  logic [NCH-1:0]        mask_q,     mask_d;
  logic [SETTLE_W-1:0]   cnt_q,      cnt_d;
  logic [NCH-1:0]        shadow_q,   shadow_d;
  ch_t                   sel_q,      sel_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic [NCH-1:0]        res_q,      res_d;
  logic                  valid_q,    valid_d;
  logic                  ovr_q,      ovr_d;
  // Overrun candidate recorded when a result lands on unread data; it becomes
  // OVR only if the consumer does not ACK during the DONE cycle.
  logic                  ovr_pend_q, ovr_pend_d;

  ch_t                   first_ch;
  logic                  first_none;
  ch_t                   nxt_ch;
  logic                  nxt_last;
  logic [NCH-1:0]        shadow_cap;

  // First enabled channel of the mask being latched at sweep start
  gf180mcu_fd_sc_mcu7t5v0__mux4_scan_nextch u_first (
    .mask_i (mask_i),
    .ch_i   ('0),
    .incl_i (1'b1),
    .next_o (first_ch),
    .last_o (first_none)
  );

  // Next enabled channel above the one currently selected
  gf180mcu_fd_sc_mcu7t5v0__mux4_scan_nextch u_next (
    .mask_i (mask_q),
    .ch_i   (ch_q),
    .incl_i (1'b0),
    .next_o (nxt_ch),
    .last_o (nxt_last)
  );

  // Next-state logic for the sweep FSM and the result handshake
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_d      = res_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    ovr_pend_d = 1'b0;
    shadow_cap = shadow_q;
    shadow_cap[ch_q] = zin_i;

    if (ack_i) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    // DONE cycle: the fresh result always survives a coincident ACK
    if (done_q) begin
      valid_d = 1'b1;
      if (ack_i) begin
        ovr_d = ovr_q;
      end else if (ovr_pend_q) begin
        ovr_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        sel_d  = '0;
        busy_d = 1'b0;
        if (start_i && !first_none) begin
          state_d  = ST_SEL;
          mask_d   = mask_i;
          ch_d     = first_ch;
          sel_d    = first_ch;
          cnt_d    = '0;
          shadow_d = '0;
          busy_d   = 1'b1;
        end
      end

      ST_SEL: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          shadow_d = shadow_cap;
          if (nxt_last) begin
            state_d    = ST_FIN;
            res_d      = shadow_cap & mask_q;
            done_d     = 1'b1;
            valid_d    = 1'b1;
            ovr_pend_d = valid_q & ~ack_i;
          end else begin
            ch_d  = nxt_ch;
            sel_d = nxt_ch;
          end
        end else begin
          cnt_d = cnt_q + SETTLE_W'(1);
        end
      end

      ST_FIN: begin
        if (cont_i && !first_none) begin
          state_d  = ST_SEL;
          mask_d   = mask_i;
          ch_d     = first_ch;
          sel_d    = first_ch;
          cnt_d    = '0;
          shadow_d = '0;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
          sel_d   = '0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial sweep
  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ovr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      ovr_pend_q <= ovr_pend_d;
    end
  end

  assign s1_o    = sel_q[1];
  assign s0_o    = sel_q[0];
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign q_o     = res_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl.sv - directed bench for the mux4 scan sequencer
module tb_gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rn, start, cont, ack;
  logic [3:0] mask, i_vec;
  logic       s0, s1, busy, done, valid, ovr;
  logic [3:0] q;
  logic       zin;
  logic [9:0] st;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  // Behavioural mux4 cell: Z = I[{S1,S0}]
  assign zin = i_vec[{s1, s0}];
  assign st  = {s1, s0, busy, done, valid, ovr, q};

  gf180mcu_fd_sc_mcu7t5v0__mux4_scan_ctrl #(.SETTLE(2), .SETTLE_W(2)) dut (
    .clk_i   (clk),
    .rn_i    (rn),
    .start_i (start),
    .cont_i  (cont),
    .mask_i  (mask),
    .zin_i   (zin),
    .s0_o    (s0),
    .s1_o    (s1),
    .busy_o  (busy),
    .done_o  (done),
    .q_o     (q),
    .valid_o (valid),
    .ack_i   (ack),
    .ovr_o   (ovr)
  );

  function automatic logic [9:0] ev(input logic [1:0] s, input logic b, input logic d,
                                    input logic v, input logic o, input logic [3:0] r);
    return {s, b, d, v, o, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Status vector {S1,S0,BUSY,DONE,VALID,OVR,Q}; ign_s masks the select bits
  task automatic chk(input string tag, input logic [9:0] exp, input logic ign_s);
    logic [9:0] o, e;
    o = ign_s ? {2'b00, st[7:0]} : st;
    e = ign_s ? {2'b00, exp[7:0]} : exp;
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  initial begin
    rn = 1'b0; start = 1'b0; cont = 1'b0; ack = 1'b0; mask = 4'h0; i_vec = 4'h0;
    tick; tick;
    chk("reset", ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0), 1'b0);
    rn = 1'b1;
    tick;
    chk("idle_after_reset", ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0), 1'b0);

    // Full sweep, I3..I0=1010, START pulsed again mid-sweep
    i_vec = 4'b1010; mask = 4'hF; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        chk("full_sel", ev(2'(k), 1'b1, 1'b0, 1'b0, 1'b0, 4'h0), 1'b0);
        start = (k == 1 && c == 0);
        tick;
      end
    end
    start = 1'b0;
    chk("full_done", ev(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010), 1'b1);
    tick;
    chk("full_idle", ev(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010), 1'b0);
    tick;
    chk("busy_start_ignored", ev(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010), 1'b0);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk("ack_clear", ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010), 1'b0);

    // Masked sweep 0101 with I=1111; mask change mid-sweep has no effect
    i_vec = 4'hF; mask = 4'b0101; start = 1'b1;
    tick;
    start = 1'b0; mask = 4'hF;
    chk("mask_ch0a", ev(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010), 1'b0);
    tick;
    chk("mask_ch0b", ev(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010), 1'b0);
    tick;
    chk("mask_ch2a", ev(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010), 1'b0);
    tick;
    chk("mask_ch2b", ev(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010), 1'b0);
    tick;
    chk("mask_done", ev(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101), 1'b1);
    tick;
    chk("mask_idle", ev(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101), 1'b0);
    ack = 1'b1;
    tick;
    ack = 1'b0;

    // START with empty mask is ignored
    mask = 4'h0; start = 1'b1;
    tick; tick;
    start = 1'b0;
    chk("mask_zero", ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101), 1'b0);

    // Continuous mode, no ACK: second result overruns the first
    cont = 1'b1; mask = 4'hF; i_vec = 4'b0011; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        chk("cont1_sel", ev(2'(k), 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101), 1'b0);
        tick;
      end
    end
    chk("cont1_done", ev(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0011), 1'b1);
    i_vec = 4'b1100;
    tick;
    cont = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        chk("cont2_sel", ev(2'(k), 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011), 1'b0);
        tick;
      end
    end
    chk("cont2_done", ev(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1100), 1'b1);
    tick;
    chk("cont2_ovr", ev(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100), 1'b0);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk("ovr_ack_clear", ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100), 1'b0);

    // ACK coincident with DONE on top of unread data
    mask = 4'b0001; i_vec = 4'b0001; start = 1'b1;
    tick;
    start = 1'b0;
    chk("one_ch_a", ev(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100), 1'b0);
    tick;
    chk("one_ch_b", ev(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100), 1'b0);
    tick;
    chk("one_ch_done", ev(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001), 1'b1);
    tick;
    i_vec = 4'b0000; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    chk("coinc_done", ev(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000), 1'b1);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk("coinc_ack", ev(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000), 1'b0);
    ack = 1'b1;
    tick;
    ack = 1'b0;

    // Asynchronous reset while channel 2 is selected
    mask = 4'hF; i_vec = 4'hF; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick; tick;
    chk("pre_rst_ch2", ev(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000), 1'b0);
    #3 rn = 1'b0;
    #1;
    chk("async_rst", ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0), 1'b0);
    tick; tick;
    rn = 1'b1;
    for (int n = 0; n < 6; n++) tick;
    chk("post_rst_quiet", ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
